// File: rtl/corridor_n.sv
// Corridor-walk safety monitor: tracks the agent's zone and door mode from claimed
// next-state flags, latches the first rule violation, a fault flag and a step budget.
module corridor_n #(
    parameter int NZONES    = 10,
    parameter int ZW        = 4,
    parameter int MAX_STEPS = 64,
    parameter int CW        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iup,
    input  logic              iright,
    input  logic [NZONES-1:0] ctl_zone,
    input  logic              ctl_open,
    input  logic              ctl_doorstep,
    input  logic              ctl_fault,
    output logic              error,
    output logic              objective,
    output logic [ZW-1:0]     zone,
    output logic [1:0]        mode,
    output logic [CW-1:0]     steps,
    output logic              timeout,
    output logic [1:0]        err_cause
);

    typedef enum logic [1:0] {
        MODE_CLOSED   = 2'd0,
        MODE_OPEN     = 2'd1,
        MODE_DOORSTEP = 2'd2
    } mode_e;

    mode_e           mode_q, mode_d;
    logic            notfirst_q, notfirst_d;
    logic [ZW-1:0]   zone_q, zone_d;
    logic            error_q, error_d;
    logic [1:0]      cause_q, cause_d;
    logic            fault_q, fault_d;
    logic [CW-1:0]   steps_q, steps_d;

    logic [NZONES:0] zone_ext;
    logic            cur_bit, nxt_bit, at_last;
    logic            viol0, viol1, viol2, viol;
    logic [1:0]      viol_cause;
    logic [ZW-1:0]   zone_move;
    logic            zone_hit;

    // The extra zero bit stands in for the nonexistent zone past the last one.
    assign zone_ext = {1'b0, ctl_zone};
    assign at_last  = (zone_q == ZW'(NZONES - 1));

    always_comb begin
        cur_bit = 1'b0;
        nxt_bit = 1'b0;
        for (int k = 0; k < NZONES; k++) begin
            if (zone_q == ZW'(k)) begin
                cur_bit = zone_ext[k];
                nxt_bit = zone_ext[k+1];
            end
        end
    end

    // Walk downward so the lowest qualifying zone wins.
    always_comb begin
        zone_move = zone_q;
        zone_hit  = 1'b0;
        for (int k = NZONES - 1; k >= 1; k--) begin
            if (ctl_zone[k] &&
                ((zone_q == ZW'(k - 1) && mode_q == MODE_DOORSTEP) ||
                 (k < NZONES - 1 && zone_q == ZW'(k + 1)))) begin
                zone_move = ZW'(k);
                zone_hit  = 1'b1;
            end
        end
    end

    assign viol0 = (mode_q == MODE_CLOSED) & iup & ctl_open;
    assign viol1 = (mode_q == MODE_OPEN) & ~iright & ctl_doorstep & cur_bit;
    assign viol2 = (mode_q == MODE_DOORSTEP) & ~at_last &
                   ((iright & ~nxt_bit) | (~iright & nxt_bit));
    assign viol  = viol0 | viol1 | viol2;

    always_comb begin
        viol_cause = 2'd3;
        if (viol0)      viol_cause = 2'd1;
        else if (viol1) viol_cause = 2'd2;
    end

    always_comb begin
        notfirst_d = notfirst_q;
        mode_d     = mode_q;
        zone_d     = zone_q;
        error_d    = error_q;
        cause_d    = cause_q;
        fault_d    = fault_q;
        steps_d    = steps_q;
        if (!notfirst_q) begin
            notfirst_d = 1'b1;
        end else begin
            if (ctl_open && ctl_doorstep) mode_d = MODE_DOORSTEP;
            else if (ctl_open)            mode_d = MODE_OPEN;
            else                          mode_d = MODE_CLOSED;

            if (ctl_zone[0])   zone_d = '0;
            else if (zone_hit) zone_d = zone_move;

            error_d = error_q | viol;
            if (!error_q && viol) cause_d = viol_cause;
            fault_d = fault_q | ctl_fault;
            if (steps_q < CW'(MAX_STEPS)) steps_d = steps_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            notfirst_q <= 1'b0;
            mode_q     <= MODE_CLOSED;
            zone_q     <= '0;
            error_q    <= 1'b0;
            cause_q    <= 2'd0;
            fault_q    <= 1'b0;
            steps_q    <= '0;
        end else begin
            notfirst_q <= notfirst_d;
            mode_q     <= mode_d;
            zone_q     <= zone_d;
            error_q    <= error_d;
            cause_q    <= cause_d;
            fault_q    <= fault_d;
            steps_q    <= steps_d;
        end
    end

    assign timeout   = (steps_q == CW'(MAX_STEPS));
    assign objective = notfirst_q & ~fault_q & ~error_q & ~timeout & at_last;
    assign error     = error_q;
    assign err_cause = cause_q;
    assign zone      = zone_q;
    assign mode      = mode_q;
    assign steps     = steps_q;

endmodule

// File: tb/tb_corridor_n.sv
// Bench for corridor_n: two instances (budget 64 and 4) share stimulus; a reference
// model pushes expected outputs per cycle, compared after each posedge.
module tb_corridor_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iup = 1'b0;
    logic       iright = 1'b0;
    logic [9:0] ctl_zone = '0;
    logic       ctl_open = 1'b0;
    logic       ctl_doorstep = 1'b0;
    logic       ctl_fault = 1'b0;

    logic       error_a, objective_a, timeout_a;
    logic [3:0] zone_a;
    logic [1:0] mode_a, cause_a;
    logic [7:0] steps_a;
    logic       error_b, objective_b, timeout_b;
    logic [3:0] zone_b;
    logic [1:0] mode_b, cause_b;
    logic [7:0] steps_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    corridor_n #(.NZONES(10), .ZW(4), .MAX_STEPS(64), .CW(8)) dut_a (
        .clk(clk), .rst(rst), .iup(iup), .iright(iright), .ctl_zone(ctl_zone),
        .ctl_open(ctl_open), .ctl_doorstep(ctl_doorstep), .ctl_fault(ctl_fault),
        .error(error_a), .objective(objective_a), .zone(zone_a), .mode(mode_a),
        .steps(steps_a), .timeout(timeout_a), .err_cause(cause_a)
    );

    corridor_n #(.NZONES(10), .ZW(4), .MAX_STEPS(4), .CW(8)) dut_b (
        .clk(clk), .rst(rst), .iup(iup), .iright(iright), .ctl_zone(ctl_zone),
        .ctl_open(ctl_open), .ctl_doorstep(ctl_doorstep), .ctl_fault(ctl_fault),
        .error(error_b), .objective(objective_b), .zone(zone_b), .mode(mode_b),
        .steps(steps_b), .timeout(timeout_b), .err_cause(cause_b)
    );

    typedef struct packed {
        logic       nf;
        logic [3:0] zone;
        logic [1:0] mode;
        logic       err;
        logic [1:0] cause;
        logic       flt;
        logic [7:0] steps;
    } mstate_t;

    mstate_t     m_a, m_b;
    logic [18:0] exp_qa[$];
    logic [18:0] exp_qb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic mstate_t model_next(mstate_t s, int maxs, logic r, logic up, logic rt,
                                           logic [9:0] cz, logic op, logic ds, logic fl);
        mstate_t     n;
        logic        v;
        int          z;
        logic [10:0] czx;
        n   = s;
        v   = 1'b0;
        z   = int'(s.zone);
        czx = {1'b0, cz};
        if (r) begin
            n = '0;
        end else if (!s.nf) begin
            n.nf = 1'b1;
        end else begin
            case (s.mode)
                2'd0:    v = up & op;
                2'd1:    v = ~rt & ds & cz[z];
                2'd2:    v = (z < 9) && (rt ? !czx[z+1] : czx[z+1]);
                default: v = 1'b0;
            endcase
            if (v && !s.err) n.cause = s.mode + 2'd1;
            n.err = s.err | v;
            n.flt = s.flt | fl;
            if (cz[0]) begin
                n.zone = 4'd0;
            end else begin
                for (int k = 1; k <= 9; k++) begin
                    if (cz[k] && ((z == k - 1 && s.mode == 2'd2) || (k < 9 && z == k + 1))) begin
                        n.zone = 4'(k);
                        break;
                    end
                end
            end
            if (int'(s.steps) < maxs) n.steps = s.steps + 8'd1;
            n.mode = (op && ds) ? 2'd2 : (op ? 2'd1 : 2'd0);
        end
        return n;
    endfunction

    // Packed order: error, objective, zone, mode, steps, timeout, err_cause.
    function automatic logic [18:0] model_out(mstate_t s, int maxs);
        logic to, obj;
        to  = (int'(s.steps) == maxs);
        obj = s.nf & ~s.flt & ~s.err & ~to & (s.zone == 4'd9);
        return {s.err, obj, s.zone, s.mode, s.steps, to, s.cause};
    endfunction

    task automatic drive(input logic r, input logic up, input logic rt, input logic [9:0] cz,
                         input logic op, input logic ds, input logic fl);
        mstate_t na, nb;
        @(negedge clk);
        rst = r; iup = up; iright = rt; ctl_zone = cz;
        ctl_open = op; ctl_doorstep = ds; ctl_fault = fl;
        na = model_next(m_a, 64, r, up, rt, cz, op, ds, fl);
        nb = model_next(m_b, 4, r, up, rt, cz, op, ds, fl);
        exp_qa.push_back(model_out(na, 64));
        exp_qb.push_back(model_out(nb, 4));
        @(posedge clk);
        #1;
        check("out_a", 32'({error_a, objective_a, zone_a, mode_a, steps_a, timeout_a, cause_a}),
              32'(exp_qa.pop_front()));
        check("out_b", 32'({error_b, objective_b, zone_b, mode_b, steps_b, timeout_b, cause_b}),
              32'(exp_qb.pop_front()));
        m_a = na;
        m_b = nb;
    endtask

    task automatic idle();
        drive(0, 0, 0, 10'd0, 0, 0, 0);
    endtask

    // Two reset cycles, then an init edge with loud inputs that must be ignored.
    task automatic reset_seq();
        drive(1, 1, 1, 10'h3ff, 1, 1, 1);
        drive(1, 0, 0, 10'h155, 1, 0, 1);
        drive(0, 1, 0, 10'h3fe, 1, 0, 1);
    endtask

    task automatic walk();
        for (int i = 0; i < 10; i++) begin
            logic [9:0] cz;
            cz = (m_a.zone < 4'd9) ? (10'd1 << (int'(m_a.zone) + 1)) : 10'd0;
            drive(0, 0, 1, cz, 1, 1, 0);
        end
    endtask

    initial begin
        int exp_steps[6];
        exp_steps = '{1, 2, 3, 4, 4, 4};
        m_a = '0;
        m_b = '0;

        reset_seq();
        check("init_steps", 32'(steps_a), 32'd0);
        check("init_error", 32'(error_a), 32'd0);

        drive(0, 1, 0, 10'd0, 1, 0, 0);
        check("m0_error", 32'(error_a), 32'd1);
        check("m0_cause", 32'(cause_a), 32'd1);
        repeat (5) idle();
        check("m0_sticky", 32'(error_a), 32'd1);
        drive(1, 0, 0, 10'd0, 0, 0, 0);
        check("m0_rst_clear", 32'(error_a), 32'd0);

        reset_seq();
        walk();
        check("walk_zone", 32'(zone_a), 32'd9);
        check("walk_error", 32'(error_a), 32'd0);
        check("walk_objective", 32'(objective_a), 32'd1);
        check("walk_obj_timeout", 32'(objective_b), 32'd0);

        reset_seq();
        drive(0, 0, 0, 10'd1, 1, 1, 0);
        drive(0, 0, 1, 10'd0, 1, 1, 0);
        check("m2_error", 32'(error_a), 32'd1);
        check("m2_cause", 32'(cause_a), 32'd3);
        check("m2_zone", 32'(zone_a), 32'd0);
        reset_seq();
        drive(0, 0, 0, 10'd1, 1, 1, 0);
        drive(0, 0, 0, 10'd2, 1, 1, 0);
        check("m2_left_error", 32'(error_a), 32'd1);

        reset_seq();
        drive(0, 0, 0, 10'd0, 0, 0, 1);
        walk();
        check("fault_zone", 32'(zone_a), 32'd9);
        check("fault_objective", 32'(objective_a), 32'd0);

        reset_seq();
        for (int i = 0; i < 6; i++) begin
            idle();
            check("budget_steps", 32'(steps_b), 32'(exp_steps[i]));
            check("budget_timeout", 32'(timeout_b), (exp_steps[i] == 4) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            logic [9:0] cz;
            cz = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) == 0 && m_a.zone < 4'd9)
                cz = 10'd1 << (int'(m_a.zone) + 1);
            drive(($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  cz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 30) == 0));
            check("zone_range", 32'(zone_a <= 4'd9), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/corridor_n.md
CORRIDOR_N -- requirements
Module: corridor_n

Interface
REQ-001 SHALL have parameter NZONES, default 10: number of corridor zones, legal range 2..16.
REQ-002 SHALL have parameter ZW, default 4: zone index width; ZW >= ceil(log2(NZONES)).
REQ-003 SHALL have parameter MAX_STEPS, default 64: step budget; legal range 1..2^CW-1.
REQ-004 SHALL have parameter CW, default 8: step counter width.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports iup and iright, input, 1 each: agent action; ileft = ~iright, idown = ~iup.
REQ-008 SHALL have port ctl_zone, input, NZONES: claimed zone membership of the next state; multi-hot allowed.
REQ-009 SHALL have ports ctl_open, ctl_doorstep and ctl_fault, input, 1 each: claimed open-area, doorstep and fault flags of the next state.
REQ-010 SHALL have ports error and objective, output, 1 each: sticky violation flag and goal flag.
REQ-011 SHALL have port zone, output, ZW: current zone index.
REQ-012 SHALL have port mode, output, 2: current mode; 0 = door closed, 1 = open, 2 = doorstep; 3 is unused.
REQ-013 SHALL have port steps, output, CW: post-init cycle count.
REQ-014 SHALL have port timeout, output, 1: step budget exhausted.
REQ-015 SHALL have port err_cause, output, 2: mode in which the first violation occurred, encoded 1/2/3 for mode 0/1/2; 0 means none.

Function
REQ-016 SHALL hold an internal notfirst flag; the first posedge after reset is the init edge: it sets notfirst, keeps all other state at reset values and ignores inputs.
REQ-017 SHALL, on each later posedge, set mode from the inputs: ctl_open & ~ctl_doorstep -> 1; ctl_open & ctl_doorstep -> 2; otherwise -> 0.
REQ-018 SHALL update zone with this priority: (1) ctl_zone[0] -> 0; (2) the lowest k in 1..NZONES-1 with ctl_zone[k] & ((zone==k-1 & mode==2) | (k<NZONES-1 & zone==k+1)) -> k; (3) otherwise hold.
REQ-019 SHALL evaluate every condition against pre-edge zone and mode (registered values), never against the next-state values.
REQ-020 SHALL flag a mode-0 violation when iup & ctl_open.
REQ-021 SHALL flag a mode-1 violation when ileft & ctl_doorstep & ctl_zone[zone].
REQ-022 SHALL flag a mode-2 violation when zone<NZONES-1 & ((iright & ~ctl_zone[zone+1]) | (ileft & ctl_zone[zone+1])); no mode-2 check applies at zone NZONES-1.
REQ-023 SHALL set error on any violation, with error sticky until rst.
REQ-024 SHALL load err_cause only on the error 0->1 edge and hold it afterwards.
REQ-025 SHALL set a sticky fault latch when ctl_fault=1.
REQ-026 SHALL increment steps by 1 on each post-init edge while steps<MAX_STEPS, then saturate at MAX_STEPS.
REQ-027 SHALL drive timeout = (steps==MAX_STEPS), combinationally from registers.
REQ-028 SHALL drive objective = notfirst & ~fault & ~error & ~timeout & (zone==NZONES-1), combinationally from registers.
REQ-029 SHALL keep updating zone, mode and steps after error or fault; only objective is gated.
REQ-030 SHALL treat any ctl_zone bit at index >= NZONES as nonexistent; the zone register SHALL never exceed NZONES-1.

Reset
REQ-031 SHALL, while rst=1 at posedge, clear notfirst, zone, mode, error, err_cause, fault and steps; rst has priority over all inputs.
REQ-032 SHALL make every output 0 during and immediately after reset.
REQ-033 SHALL, when rst is asserted mid-episode, have the following edge act as the init edge again (REQ-016).

Verification (NZONES=10 unless stated)
REQ-034 Reset: rst=1 for 2 cycles, then release -> all outputs 0; inputs applied on the init edge have no effect, so steps=0 after it.
REQ-035 Mode-0 violation: post-init, mode=0, iup=1, ctl_open=1 -> error=1, err_cause=1 next cycle; error stays 1 for 5 benign cycles; rst clears it.
REQ-036 Doorstep walk: each cycle ctl_open=ctl_doorstep=1, iright=1, ctl_zone one-hot at zone+1 -> zone steps 0..9, error=0; objective=1 once zone=9.
REQ-037 Mode-2 mismatch: zone=0, mode=2, iright=1, ctl_zone=0 -> error=1, err_cause=3, zone stays 0; separately ileft=1 with ctl_zone[1]=1 -> error=1.
REQ-038 Fault gating: one cycle of ctl_fault=1, then the REQ-036 walk -> zone reaches 9, objective stays 0.
REQ-039 Budget: MAX_STEPS=4, idle inputs for 6 post-init cycles -> steps 1,2,3,4,4,4; timeout=1 from steps=4; objective forced 0 at zone 9.
